sw_lap_ctrl: RTL

Mode controller and lap scheduler for the stopwatch datapath. It sits between the debounced button pulses and the stopwatch core, and between the core's BCD digits and the display multiplexer. It converts user pulses into one-cycle start/stop/clear commands through a mode FSM. It also captures lap times into a small buffer and chooses whether the display shows live time or a stored lap.

---
 rtl/sw_lap_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/sw_lap_ctrl.sv
//------------------------------------------------------------------------------
// sw_lap_ctrl : stopwatch mode FSM, lap capture buffer and display source select.
// Optional macro LAP_REVIEW_EN builds the REVIEW state for browsing stored laps.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module sw_lap_ctrl #(
    parameter int LAP_DEPTH   = 4,
    parameter int HOLD_CYCLES = 200000000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start_p,
    input  logic                           stop_p,
    input  logic                           clear_p,
    input  logic                           lap_p,
    input  logic [3:0]                     live_min,
    input  logic [3:0]                     live_st,
    input  logic [3:0]                     live_su,
    input  logic [3:0]                     live_ten,
    output logic                           sw_start,
    output logic                           sw_stop,
    output logic                           sw_clear,
    output logic [3:0]                     disp_min,
    output logic [3:0]                     disp_st,
    output logic [3:0]                     disp_su,
    output logic [3:0]                     disp_ten,
    output logic                           lap_view,
    output logic [$clog2(LAP_DEPTH+1)-1:0] lap_cnt,
    output logic                           lap_full,
    output logic                           running
);

    localparam int c_CW = $clog2(LAP_DEPTH + 1);
    localparam int c_IW = $clog2(LAP_DEPTH);
    localparam int c_HW = $clog2(HOLD_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_PAUSED = 2'd2
`ifdef LAP_REVIEW_EN
        , S_REVIEW = 2'd3
`endif
    } state_t;

    state_t            r_state, w_state_nxt;
    logic              r_sw_start, r_sw_stop, r_sw_clear;
    logic              w_cmd_start, w_cmd_stop, w_cmd_clear;
    logic [15:0]       r_disp, w_disp_nxt;
    logic              r_lap_view, w_view_nxt;
    logic [c_CW-1:0]   r_lap_cnt, w_cnt_nxt;
    logic              r_lap_full, r_running;
    logic [c_HW-1:0]   r_hold, w_hold_nxt;
    logic [15:0]       r_slots [LAP_DEPTH];
    logic              w_accept, w_holding;
    logic              w_clr, w_stp, w_sta, w_lap;
    logic [15:0]       w_live;

`ifdef LAP_REVIEW_EN
    logic [c_IW-1:0]   r_idx, w_idx_nxt;
    logic              w_idx_last;
    assign w_idx_last = (c_CW'(r_idx) + c_CW'(1)) == r_lap_cnt;
`endif

    assign w_live = {live_min, live_st, live_su, live_ten};

    // Only the highest-priority pulse of a cycle survives
    assign w_clr = clear_p;
    assign w_stp = stop_p & ~clear_p;
    assign w_sta = start_p & ~stop_p & ~clear_p;
    assign w_lap = lap_p & ~start_p & ~stop_p & ~clear_p;

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_start = 1'b0;
        w_cmd_stop  = 1'b0;
        w_cmd_clear = 1'b0;
        w_accept    = 1'b0;
        w_cnt_nxt   = r_lap_cnt;
`ifdef LAP_REVIEW_EN
        w_idx_nxt   = r_idx;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_sta) begin
                    w_state_nxt = S_RUN;
                    w_cmd_start = 1'b1;
                end else if (w_clr) begin
                    w_cmd_clear = 1'b1;
                end
            end
            S_RUN: begin
                if (w_stp) begin
                    w_state_nxt = S_PAUSED;
                    w_cmd_stop  = 1'b1;
                end else if (w_lap && !r_lap_full) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = r_lap_cnt + c_CW'(1);
                end
            end
            S_PAUSED: begin
                if (w_sta) begin
                    w_state_nxt = S_RUN;
                    w_cmd_start = 1'b1;
                end else if (w_clr) begin
                    w_state_nxt = S_IDLE;
                    w_cmd_clear = 1'b1;
                    w_cnt_nxt   = '0;
                end
`ifdef LAP_REVIEW_EN
                else if (w_lap && (r_lap_cnt != '0)) begin
                    w_state_nxt = S_REVIEW;
                    w_idx_nxt   = '0;
                end
`endif
            end
`ifdef LAP_REVIEW_EN
            S_REVIEW: begin
                if (w_sta) begin
                    w_state_nxt = S_RUN;
                    w_cmd_start = 1'b1;
                end else if (w_clr) begin
                    w_state_nxt = S_IDLE;
                    w_cmd_clear = 1'b1;
                    w_cnt_nxt   = '0;
                end else if (w_stp) begin
                    w_state_nxt = S_PAUSED;
                end else if (w_lap) begin
                    w_idx_nxt = w_idx_last ? '0 : r_idx + c_IW'(1);
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase

        // Hold survives only while staying in RUN; a fresh lap restarts it
        w_holding  = (r_state == S_RUN) && (w_state_nxt == S_RUN) && (r_hold != '0);
        w_hold_nxt = '0;
        w_view_nxt = 1'b0;
        w_disp_nxt = w_live;
        if (w_accept) begin
            w_hold_nxt = c_HW'(HOLD_CYCLES - 1);
            w_view_nxt = 1'b1;
        end else if (w_holding) begin
            w_hold_nxt = r_hold - c_HW'(1);
            w_view_nxt = 1'b1;
            w_disp_nxt = r_disp;
        end
`ifdef LAP_REVIEW_EN
        if (w_state_nxt == S_REVIEW) begin
            w_view_nxt = 1'b1;
            w_disp_nxt = r_slots[w_idx_nxt];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_sw_start <= 1'b0;
            r_sw_stop  <= 1'b0;
            r_sw_clear <= 1'b0;
            r_disp     <= '0;
            r_lap_view <= 1'b0;
            r_lap_cnt  <= '0;
            r_lap_full <= 1'b0;
            r_running  <= 1'b0;
            r_hold     <= '0;
`ifdef LAP_REVIEW_EN
            r_idx      <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_sw_start <= w_cmd_start;
            r_sw_stop  <= w_cmd_stop;
            r_sw_clear <= w_cmd_clear;
            r_disp     <= w_disp_nxt;
            r_lap_view <= w_view_nxt;
            r_lap_cnt  <= w_cnt_nxt;
            r_lap_full <= (w_cnt_nxt == c_CW'(LAP_DEPTH));
            r_running  <= (w_state_nxt == S_RUN);
            r_hold     <= w_hold_nxt;
`ifdef LAP_REVIEW_EN
            r_idx      <= w_idx_nxt;
`endif
        end
    end

    // Slot storage is never cleared; lap_cnt alone bounds what is reachable
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_slots[r_lap_cnt[c_IW-1:0]] <= w_live;
        end
    end

    assign sw_start = r_sw_start;
    assign sw_stop  = r_sw_stop;
    assign sw_clear = r_sw_clear;
    assign {disp_min, disp_st, disp_su, disp_ten} = r_disp;
    assign lap_view = r_lap_view;
    assign lap_cnt  = r_lap_cnt;
    assign lap_full = r_lap_full;
    assign running  = r_running;

endmodule

`default_nettype wire
